// File: rtl/sop_sweep_pkg.sv
// Shared definitions for the sum-of-products sweep sequencer.
//   state_t : sweep FSM states (IDLE, HOLD, DONE)
//   VEC_W   : width of the applied input vector {x,y,w,z}
//   NUM_VEC : number of input vectors in an exhaustive 4-variable sweep
//   CNT_W   : width of the per-vector settle counter
package sop_sweep_pkg;

    localparam int VEC_W   = 4;
    localparam int NUM_VEC = 16;
    localparam int CNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sop_mask_eval.sv
// Golden model for a canonical 4-variable sum of products: the expected
// output is simply the minterm-mask bit selected by the applied vector.
//   mask  : in  16  minterm mask, bit i = f(vector i)
//   vec   : in  4   applied vector {x,y,w,z}, x = MSB
//   s_ref : out 1   expected function value for vec
module sop_mask_eval
    import sop_sweep_pkg::*;
(
    input  logic [NUM_VEC-1:0] mask,
    input  logic [VEC_W-1:0]   vec,
    output logic               s_ref
);

    assign s_ref = mask[vec];

endmodule

// File: rtl/sop_sweep_ctrl.sv
// Exhaustive sweep sequencer for a 4-input combinational SoP/PoS circuit.
// Applies all 16 vectors, holds each for SETTLE+1 cycles, samples the
// circuit output on the last cycle of each vector and compares it with a
// canonical minterm mask. Records the observed truth table, the mismatch
// count and the lowest failing vector.
//
// Optional build macro: STOP_ON_FAIL_EN -- when defined, the sweep ends at
// the first mismatching vector instead of visiting all 16.
//
// Ports:
//   clk          : in  1   rising-edge clock
//   rst_n        : in  1   asynchronous active-low reset
//   start        : in  1   begin a sweep (accepted only while idle)
//   mask         : in  16  expected minterms, latched on start
//   vec          : out 4   applied vector {x,y,w,z}
//   s_ext        : in  1   output of the circuit under check
//   s_ref        : out 1   expected value for the current vector
//   busy         : out 1   sweep in progress (HOLD or DONE)
//   done         : out 1   one-cycle pulse at the end of a sweep
//   table_out    : out 16  observed truth table
//   mismatch_cnt : out 5   number of mismatching vectors
//   first_fail   : out 4   lowest failing vector (valid when fail=1)
//   fail         : out 1   at least one mismatch in the last sweep
//
// Handshake: start is a level sampled on the rising edge; it is taken only
// when busy=0 and is ignored otherwise. done pulses for one cycle, after
// which busy drops and the results hold until the next accepted start.
module sop_sweep_ctrl
    import sop_sweep_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [NUM_VEC-1:0] mask,
    output logic [VEC_W-1:0]   vec,
    input  logic               s_ext,
    output logic               s_ref,
    output logic               busy,
    output logic               done,
    output logic [NUM_VEC-1:0] table_out,
    output logic [4:0]         mismatch_cnt,
    output logic [VEC_W-1:0]   first_fail,
    output logic               fail
);

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [NUM_VEC-1:0] mask_q;
    logic               ext_one;
    logic               sample_edge;
    logic               miss;
    logic               last_vec;
    logic               stop_now;

    sop_mask_eval u_mask_eval (
        .mask  (mask_q),
        .vec   (vec),
        .s_ref (s_ref)
    );

    always_comb begin
        // An undriven (X/Z) s_ext falls to the else branch and is treated
        // as 0: it mismatches a 1 expectation but never a 0 expectation.
        ext_one = 1'b0;
        if (s_ext) begin
            ext_one = 1'b1;
        end
        sample_edge = (state == HOLD) && (cnt == '0);
        miss        = sample_edge && (ext_one != s_ref);
        last_vec    = (vec == VEC_W'(NUM_VEC - 1));
`ifdef STOP_ON_FAIL_EN
        stop_now    = miss;
`else
        stop_now    = 1'b0;
`endif
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (sample_edge && (last_vec || stop_now)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec          <= '0;
            cnt          <= '0;
            mask_q       <= '0;
            table_out    <= '0;
            mismatch_cnt <= '0;
            first_fail   <= '0;
            fail         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mask_q       <= mask;
                        table_out    <= '0;
                        mismatch_cnt <= '0;
                        first_fail   <= '0;
                        fail         <= 1'b0;
                        vec          <= '0;
                        cnt          <= CNT_W'(SETTLE);
                    end
                end
                HOLD: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        table_out[vec] <= s_ext;
                        if (miss) begin
                            mismatch_cnt <= mismatch_cnt + 5'd1;
                            if (!fail) begin
                                first_fail <= vec;
                                fail       <= 1'b1;
                            end
                        end
                        // vec stays put on the final (or stopping) vector
                        if (!last_vec && !stop_now) begin
                            vec <= vec + 1'b1;
                            cnt <= CNT_W'(SETTLE);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sop_sweep_ctrl.sv
// Self-checking bench for sop_sweep_ctrl. The circuit under check is a
// 16-entry truth table (ckt) indexed by the applied vector; expected results
// are derived from the mask and that table with plain bit arithmetic.
module tb_sop_sweep_ctrl;

    localparam int S   = 1;
    localparam int NV  = 16;
    localparam int BUDGET = 200;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] mask_in;
    logic [3:0]  vec;
    logic        s_ext;
    logic        s_ref;
    logic        busy;
    logic        done;
    logic [15:0] table_out;
    logic [4:0]  mismatch_cnt;
    logic [3:0]  first_fail;
    logic        fail;

    logic [15:0] ckt;
    int          n_checks;
    int          n_fails;

    sop_sweep_ctrl #(.SETTLE(S)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .mask         (mask_in),
        .vec          (vec),
        .s_ext        (s_ext),
        .s_ref        (s_ref),
        .busy         (busy),
        .done         (done),
        .table_out    (table_out),
        .mismatch_cnt (mismatch_cnt),
        .first_fail   (first_fail),
        .fail         (fail)
    );

    // external circuit under check
    assign s_ext = ckt[vec];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // simplified form of minterms {1,2,5,9,10,11}
    function automatic logic f_simpl(input int i);
        logic x, y, w, z;
        {x, y, w, z} = 4'(i);
        return (!x && !w && z) || (!y && !w && z) || (!y && w && !z) || (x && !y && w);
    endfunction

    task automatic run_sweep(input string tag, input logic [15:0] m,
                             input logic [15:0] circ, input int restart_at);
        logic [15:0] diff;
        logic [15:0] exp_table;
        int          exp_cnt;
        int          exp_first;
        int          exp_vec;
        int          lat;
        int          k;
        int          v;
        diff      = circ ^ m;
        exp_cnt   = $countones(diff);
        exp_first = 0;
        for (int i = NV - 1; i >= 0; i--) begin
            if (diff[i]) exp_first = i;
        end
        exp_table = circ;
        exp_vec   = NV - 1;
        lat       = NV * (S + 1);
`ifdef STOP_ON_FAIL_EN
        if (diff != 16'h0) begin
            exp_cnt   = 1;
            exp_vec   = exp_first;
            lat       = (exp_first + 1) * (S + 1);
            exp_table = circ & 16'((32'd1 << (exp_first + 1)) - 1);
        end
`endif
        ckt = circ;
        @(negedge clk);
        mask_in = m;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        mask_in = ~m;   // mask must already be latched
        k = 0;
        while (!done && k < BUDGET) begin
            v = k / (S + 1);
            chk({tag, " vec"}, 32'(vec), 32'(v));
            chk({tag, " s_ref"}, 32'(s_ref), 32'(m[v]));
            chk({tag, " busy"}, 32'(busy), 32'd1);
            start = (k == restart_at);
            @(posedge clk);
            #1;
            k++;
        end
        start = 1'b0;
        chk({tag, " latency"}, 32'(k), 32'(lat));
        chk({tag, " done"}, 32'(done), 32'd1);
        chk({tag, " final vec"}, 32'(vec), 32'(exp_vec));
        chk({tag, " table"}, 32'(table_out), 32'(exp_table));
        chk({tag, " mismatch_cnt"}, 32'(mismatch_cnt), 32'(exp_cnt));
        chk({tag, " fail"}, 32'(fail), 32'(diff != 16'h0));
        chk({tag, " first_fail"}, 32'(first_fail), 32'(exp_first));
        @(posedge clk);
        #1;
        chk({tag, " done pulse width"}, 32'(done), 32'd0);
        chk({tag, " busy after"}, 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, " no second done"}, 32'(done), 32'd0);
        chk({tag, " table stable"}, 32'(table_out), 32'(exp_table));
        chk({tag, " cnt stable"}, 32'(mismatch_cnt), 32'(exp_cnt));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " vec"}, 32'(vec), 32'd0);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " done"}, 32'(done), 32'd0);
        chk({tag, " table"}, 32'(table_out), 32'd0);
        chk({tag, " mismatch_cnt"}, 32'(mismatch_cnt), 32'd0);
        chk({tag, " first_fail"}, 32'(first_fail), 32'd0);
        chk({tag, " fail"}, 32'(fail), 32'd0);
        chk({tag, " s_ref"}, 32'(s_ref), 32'd0);
    endtask

    initial begin
        logic [15:0] good;
        logic [15:0] rm;
        logic [15:0] rerr;
        logic        saw_done;
        n_checks = 0;
        n_fails  = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        mask_in  = 16'h0;
        ckt      = 16'h0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_zero("post reset idle");

        // correct simplified circuit
        good = 16'h0;
        for (int i = 0; i < NV; i++) good[i] = f_simpl(i);
        chk("simplified circuit table", 32'(good), 32'h0E26);
        run_sweep("correct", 16'h0E26, good, -1);

        // output tied low
        run_sweep("tied0", 16'h0E26, 16'h0000, -1);

        // minterm 11 dropped
        run_sweep("drop11", 16'h0E26, 16'h0626, -1);

        // output tied high
        run_sweep("tied1", 16'h0E26, 16'hFFFF, -1);

        // start pulsed again mid-sweep
        run_sweep("restart ignored", 16'h0E26, good, 10);

        // reset mid-sweep
        ckt = good;
        @(negedge clk);
        mask_in = 16'h0E26;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_zero("mid-sweep reset");
        saw_done = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        chk("mid-sweep reset no done", 32'(saw_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_sweep("after reset", 16'h0E26, good, -1);

        // random masks against circuits with sparse random faults
        for (int t = 0; t < 8; t++) begin
            rm   = 16'($urandom);
            rerr = 16'($urandom) & 16'($urandom) & 16'($urandom);
            if ($urandom_range(0, 3) == 0) rerr = 16'h0;
            run_sweep($sformatf("rand%0d", t), rm, rm ^ rerr, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/sop_sweep_ctrl.md
Name: sop_sweep_ctrl

Overview:
- Sequencer that drives a 4-input combinational sum-of-products circuit (x,y,w,z) through all 16 input vectors.
- Samples the circuit output and checks it against a canonical minterm mask.
- Records the observed truth table, the mismatch count and the first failing minterm.
- Sits between a bench or top-level and any SoP/PoS implementation under check, replacing hand-written exhaustive stimulus.

Parameters:
SETTLE, 1, extra clocks each vector is held before sampling (0..15); each vector occupies SETTLE+1 cycles.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a sweep; accepted only in IDLE
mask  input  16  expected minterms; bit i = expected f for vector i; latched on start
vec  output  4  applied vector {x,y,w,z}, x = MSB
s_ext  input  1  output of external circuit under check
s_ref  output  1  mask_q[vec], canonical expected value for current vector
busy  output  1  high from the cycle after start until done
done  output  1  one-cycle pulse at end of sweep
table_out  output  16  observed truth table; bit i = s_ext sampled at vector i
mismatch_cnt  output  5  number of vectors where s_ext != s_ref (0..16)
first_fail  output  4  lowest failing vector index; valid when fail=1
fail  output  1  at least one mismatch in last sweep

Behaviour:
- Reset (async, rst_n=0): state IDLE; vec=0; busy=0; done=0; table_out=0; mismatch_cnt=0; first_fail=0; fail=0; mask_q=0; settle counter=0. Reset mid-sweep aborts immediately with no done pulse.
- FSM states: IDLE, HOLD, DONE.
- IDLE:
  - start=1 latches mask_q<=mask; clears table_out, mismatch_cnt, first_fail and fail; sets vec<=0 and cnt<=SETTLE; moves to HOLD.
  - Otherwise holds, keeping the previous results.
- HOLD:
  - If cnt!=0: cnt<=cnt-1.
  - If cnt==0 (sample edge): table_out[vec]<=s_ext.
  - On s_ext!=mask_q[vec] at the sample edge: mismatch_cnt++. If fail==0, then first_fail<=vec and fail<=1.
  - Then if vec==15, go to DONE. Otherwise vec<=vec+1, cnt<=SETTLE.
- DONE: done=1 for exactly one cycle, then IDLE. vec stays 15.
- busy=1 in HOLD and DONE, 0 in IDLE.
- start is ignored in HOLD and DONE. Results are stable from done until the next accepted start.
- Timing: the sweep lasts 16*(SETTLE+1) cycles in HOLD. done is high on cycle 16*(SETTLE+1)+1 after the start edge.
- s_ext may be X or Z (unconnected); the compare treats non-1 as mismatch against a 1 and does not increment on a 0 expectation. A bench must drive known values.
- vec wraps only via restart; no modulo increment past 15.
- mismatch_cnt saturates at 16 by construction (max one per vector).

Optional Feature:
STOP_ON_FAIL_EN
- Defined: at the first mismatch sample edge the FSM goes to DONE instead of advancing. vec stays at the failing index, mismatch_cnt=1, and unvisited table_out bits remain 0.
- Undefined: the full 16-vector sweep always runs and all mismatches are counted.

Decomposition:
- Package sop_sweep_pkg holds:
  - state enum {IDLE, HOLD, DONE}
  - VEC_W=4
  - NUM_VEC=16
  - CNT_W=4
- Sub-module sop_mask_eval (combinational): mask_q[vec] -> s_ref. It is reusable as the golden model for any 4-variable canonical SoP.
- FSM, counters and result registers stay in sop_sweep_ctrl.

Test Plan:
- SETTLE=1, mask=16'h0E26 (minterms 1,2,5,9,10,11), s_ext driven by a correct simplified circuit -> done at cycle 33 after start, table_out=16'h0E26, mismatch_cnt=0, fail=0.
- Same mask, s_ext tied 0 -> table_out=16'h0000, mismatch_cnt=6, fail=1, first_fail=1.
- Same mask, s_ext = circuit with minterm 11 dropped -> mismatch_cnt=1, first_fail=11, table_out=16'h0626.
- start pulsed again at cycle 10 of a sweep -> ignored; the sweep completes once, with a single done pulse.
- rst_n low at cycle 12 mid-sweep -> all outputs zero immediately, no done. A new start gives a full clean sweep.
- STOP_ON_FAIL_EN defined, s_ext tied 1, mask=16'h0E26 -> stops at vec=0, done at cycle 3, mismatch_cnt=1, first_fail=0.
